// File: rtl/oam_dma_ctrl_pkg.sv
// Shared 2A03 bus definitions: fixed register addresses, bus direction encoding
// and the OAM DMA state encoding.
package nes_bus_pkg;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // READ and WRITE share the low code 2'b11; bit 2 is the read/write phase.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd7
    } state_t;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and system-bus-side signals of the OAM DMA engine.
// There is no handshake: every bus transfer completes in the cycle it is presented.
interface oam_dma_ctrl_if;

    logic [7:0] cpu_addr_l;
    logic [7:0] cpu_addr_h;
    logic       cpu_rw;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_halt;

    logic [7:0] bus_addr_l;
    logic [7:0] bus_addr_h;
    logic       bus_rw;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       dma_busy;

    // master: CPU core plus system memory; slave: the DMA engine in between.
    modport master (
        output cpu_addr_l, cpu_addr_h, cpu_rw, cpu_wdata, bus_rdata,
        input  cpu_rdata, cpu_halt, bus_addr_l, bus_addr_h, bus_rw, bus_wdata, dma_busy
    );

    modport slave (
        input  cpu_addr_l, cpu_addr_h, cpu_rw, cpu_wdata, bus_rdata,
        output cpu_rdata, cpu_halt, bus_addr_l, bus_addr_h, bus_rw, bus_wdata, dma_busy
    );

endinterface

// File: rtl/oam_dma_ctrl_byte_counter.sv
// 8-bit source index counter for the OAM copy; wraps naturally from 8'hFF to 0.
module dma_byte_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       inc_i,
    output logic [7:0] count_o,
    output logic       last_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (inc_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == 8'hFF);

endmodule

// File: rtl/oam_dma_ctrl.sv
// 2A03 sprite DMA: a CPU write to the DMA register halts the core and copies one
// 256-byte page to the OAM data port; otherwise CPU traffic passes straight through.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = nes_bus_pkg::DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = nes_bus_pkg::OAM_DATA_ADDR,
    parameter bit          ALIGN_ENABLE  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    oam_dma_ctrl_if.slave       bus_if,
    output nes_bus_pkg::state_t state_o
);

    import nes_bus_pkg::*;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  page_q;
    logic [7:0]  page_d;
    logic [7:0]  latch_q;
    logic [7:0]  latch_d;
    logic        parity_q;

    logic [7:0]  idx;
    logic        idx_last;
    logic        idx_inc;
    logic        start;

    logic [15:0] cpu_addr;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_wdata;
    logic        halt;

    assign cpu_addr = {bus_if.cpu_addr_h, bus_if.cpu_addr_l};
    assign start    = (state_q == ST_IDLE) && (bus_if.cpu_rw == RW_WRITE)
                      && (cpu_addr == DMA_REG_ADDR);
    assign idx_inc  = (state_q == ST_WRITE);

    dma_byte_counter u_idx (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start),
        .inc_i   (idx_inc),
        .count_o (idx),
        .last_o  (idx_last)
    );

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        latch_d   = latch_q;
        bus_addr  = cpu_addr;
        bus_rw    = bus_if.cpu_rw;
        bus_wdata = bus_if.cpu_wdata;
        halt      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The register write itself still reaches the bus.
                if (start) begin
                    state_d = ST_HALT;
                    page_d  = bus_if.cpu_wdata;
                end
            end
            ST_HALT: begin
                halt    = 1'b1;
                state_d = (ALIGN_ENABLE && !parity_q) ? ST_ALIGN : ST_READ;
            end
            ST_ALIGN: begin
                halt    = 1'b1;
                bus_rw  = RW_READ;
                state_d = ST_READ;
            end
            ST_READ: begin
                halt     = 1'b1;
                bus_rw   = RW_READ;
                bus_addr = {page_q, idx};
                latch_d  = bus_if.bus_rdata;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                halt      = 1'b1;
                bus_rw    = RW_WRITE;
                bus_addr  = OAM_DATA_ADDR;
                bus_wdata = latch_q;
                state_d   = idx_last ? ST_IDLE : ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'd0;
            latch_q  <= 8'd0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            latch_q  <= latch_d;
            parity_q <= ~parity_q;
        end
    end

    assign bus_if.bus_addr_l = bus_addr[7:0];
    assign bus_if.bus_addr_h = bus_addr[15:8];
    assign bus_if.bus_rw     = bus_rw;
    assign bus_if.bus_wdata  = bus_wdata;
    assign bus_if.cpu_rdata  = bus_if.bus_rdata;
    assign bus_if.cpu_halt   = halt;
    assign bus_if.dma_busy   = (state_q != ST_IDLE);
    assign state_o           = state_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: two instances (alignment on/off) share CPU stimulus and a
// 64 KiB memory; each DMA run is compared against the expected 256-byte copy trace.
module tb_oam_dma_ctrl;

    import nes_bus_pkg::*;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
        logic        halt;
        logic [7:0]  cin_wd;
    } cyc_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] cpu_al;
    logic [7:0] cpu_ah;
    logic [7:0] cpu_wd;
    logic       cpu_rw;
    logic [7:0] mem [65536];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    cyc_t tr_a[$];
    cyc_t tr_b[$];

    oam_dma_ctrl_if if_a ();
    oam_dma_ctrl_if if_b ();
    state_t st_a;
    state_t st_b;

    assign if_a.cpu_addr_l = cpu_al;
    assign if_a.cpu_addr_h = cpu_ah;
    assign if_a.cpu_rw     = cpu_rw;
    assign if_a.cpu_wdata  = cpu_wd;
    assign if_a.bus_rdata  = mem[{if_a.bus_addr_h, if_a.bus_addr_l}];
    assign if_b.cpu_addr_l = cpu_al;
    assign if_b.cpu_addr_h = cpu_ah;
    assign if_b.cpu_rw     = cpu_rw;
    assign if_b.cpu_wdata  = cpu_wd;
    assign if_b.bus_rdata  = mem[{if_b.bus_addr_h, if_b.bus_addr_l}];

    oam_dma_ctrl #(.ALIGN_ENABLE(1'b1)) dut_a (.clk(clk), .rst(rst), .bus_if(if_a), .state_o(st_a));
    oam_dma_ctrl #(.ALIGN_ENABLE(1'b0)) dut_b (.clk(clk), .rst(rst), .bus_if(if_b), .state_o(st_b));

    // Cycle index since reset; its LSB is the expected parity of that cycle.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] wd);
        cpu_ah = a[15:8];
        cpu_al = a[7:0];
        cpu_rw = rw;
        cpu_wd = wd;
    endtask

    // Both engines idle: bus mirrors CPU, read data comes from memory, no halt.
    task automatic check_pass(input string tag);
        logic [15:0] a;
        logic [63:0] e;
        a = {cpu_ah, cpu_al};
        e = {29'd0, a, cpu_rw, cpu_wd, mem[a], 1'b0, 1'b0};
        check({tag, "_a"}, {29'd0, if_a.bus_addr_h, if_a.bus_addr_l, if_a.bus_rw, if_a.bus_wdata,
                            if_a.cpu_rdata, if_a.cpu_halt, if_a.dma_busy}, e);
        check({tag, "_b"}, {29'd0, if_b.bus_addr_h, if_b.bus_addr_l, if_b.bus_rw, if_b.bus_wdata,
                            if_b.cpu_rdata, if_b.cpu_halt, if_b.dma_busy}, e);
    endtask

    task automatic idle_cycle(input string tag);
        logic [15:0] a;
        logic        rw;
        @(posedge clk);
        #1;
        a  = 16'($urandom);
        rw = 1'($urandom_range(0, 1));
        if (!rw && a == DMA_REG_ADDR) rw = 1'b1;
        drive(a, rw, 8'($urandom));
        @(negedge clk);
        check_pass(tag);
    endtask

    // Expected halted trace: dummy cycle, optional alignment read, then 256 read/write pairs.
    task automatic verify(input cyc_t tr[$], input logic [7:0] page, input bit align,
                          input logic [15:0] hold_addr, input logic hold_rw, input string who);
        int off;
        off = align ? 2 : 1;
        check({who, "_halt_cycles"}, 64'(tr.size()), 64'(513 + int'(align)));
        if (tr.size() >= off + 512) begin
            check({who, "_dummy"}, {tr[0].addr, tr[0].rw, tr[0].wdata, tr[0].halt},
                  {hold_addr, hold_rw, tr[0].cin_wd, 1'b1});
            if (align)
                check({who, "_align"}, {tr[1].addr, tr[1].rw, tr[1].wdata, tr[1].halt},
                      {hold_addr, 1'b1, tr[1].cin_wd, 1'b1});
            for (int i = 0; i < 256; i++) begin
                cyc_t r;
                cyc_t w;
                r = tr[off + 2 * i];
                w = tr[off + 2 * i + 1];
                check($sformatf("%s_read_%0d", who, i), {r.addr, r.rw, r.wdata, r.halt},
                      {page, 8'(i), 1'b1, r.cin_wd, 1'b1});
                check($sformatf("%s_write_%0d", who, i), {w.addr, w.rw, w.wdata, w.halt},
                      {OAM_DATA_ADDR, 1'b0, mem[{page, 8'(i)}], 1'b1});
            end
        end
    endtask

    task automatic run_dma(input logic [7:0] page, input bit halt_par, input bit spurious);
        logic [15:0] hold_addr;
        logic        hold_rw;
        logic [7:0]  hold_wd;
        bit          done;
        @(posedge clk);
        #1;
        if (((cyc + 1) % 2) != int'(halt_par)) begin
            drive(16'h8000, 1'b1, 8'h00);
            @(posedge clk);
            #1;
        end
        drive(DMA_REG_ADDR, 1'b0, page);
        @(negedge clk);
        check_pass("start_fwd");
        @(posedge clk);
        #1;
        hold_addr = 16'($urandom);
        hold_rw   = 1'($urandom_range(0, 1));
        hold_wd   = 8'($urandom);
        if (!hold_rw && hold_addr == DMA_REG_ADDR) hold_rw = 1'b1;
        drive(hold_addr, hold_rw, hold_wd);
        tr_a.delete();
        tr_b.delete();
        done = 0;
        for (int n = 0; n < 700 && !done; n++) begin
            @(negedge clk);
            if (if_a.dma_busy)
                tr_a.push_back('{addr: {if_a.bus_addr_h, if_a.bus_addr_l}, rw: if_a.bus_rw,
                                 wdata: if_a.bus_wdata, halt: if_a.cpu_halt, cin_wd: cpu_wd});
            if (if_b.dma_busy)
                tr_b.push_back('{addr: {if_b.bus_addr_h, if_b.bus_addr_l}, rw: if_b.bus_rw,
                                 wdata: if_b.bus_wdata, halt: if_b.cpu_halt, cin_wd: cpu_wd});
            if (!if_a.dma_busy && !if_b.dma_busy) done = 1;
            else if (spurious && n == 12) drive(DMA_REG_ADDR, 1'b0, 8'($urandom));
            else if (spurious && n == 30) drive(hold_addr, hold_rw, hold_wd);
        end
        check("dma_completes", 64'(done), 64'd1);
        check_pass("dma_exit");
        verify(tr_a, page, !halt_par, hold_addr, hold_rw, "align_on");
        verify(tr_b, page, 1'b0, hold_addr, hold_rw, "align_off");
    endtask

    task automatic reset_mid_dma(input logic [7:0] page);
        int writes;
        @(posedge clk);
        #1;
        drive(DMA_REG_ADDR, 1'b0, page);
        @(posedge clk);
        #1;
        drive(16'h8000, 1'b1, 8'h00);
        writes = 0;
        for (int n = 0; n < 700 && writes < 100; n++) begin
            @(negedge clk);
            if (if_a.dma_busy && if_a.bus_rw == RW_WRITE) writes++;
        end
        check("writes_before_reset", 64'(writes), 64'd100);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_pass("after_reset");
        check("after_reset_state", {56'd0, 5'(st_a), 3'(st_b)}, {56'd0, 5'(ST_IDLE), 3'(ST_IDLE)});
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
        mem[16'h8000] = 8'h5A;

        rst = 1'b1;
        drive(16'h8000, 1'b1, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {56'd0, 5'(st_a), 3'(st_b)}, {56'd0, 5'(ST_IDLE), 3'(ST_IDLE)});
        check_pass("reset_pass");
        check("pass_rdata_5a", 64'(if_a.cpu_rdata), 64'h5A);

        for (int k = 0; k < 8; k++) idle_cycle("idle_pass");

        run_dma(8'h02, 1'b1, 1'b0);
        run_dma(8'($urandom), 1'b0, 1'b0);
        run_dma(8'h03, 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("page3_copy_%0d", i), {48'd0, tr_a[tr_a.size() - 512 + 2 * i + 1].wdata},
                  {48'd0, 8'(i) ^ 8'hA5});
        end
        run_dma(8'hFF, 1'($urandom_range(0, 1)), 1'b0);
        idle_cycle("after_wrap");

        reset_mid_dma(8'($urandom));
        run_dma(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        run_dma(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        for (int k = 0; k < 4; k++) idle_cycle("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
